// File: rtl/fifo_pop_packer_pkg.sv
// Shared types for the FIFO pop packer: flush FSM states and lane-counter sizing.
package fifo_pop_packer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  // Lane counter holds 0..ratio-1; a 2-lane packer still needs one bit.
  function automatic int lane_width(input int ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_pop_packer_lane_accumulator.sv
// Collects popped words lane by lane and presents both the completed full beat
// and the partial accumulator (unused lanes kept at zero) with its keep mask.
module fifo_pop_packer_lane_accumulator
  import fifo_pop_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4,
  parameter int LW    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_capture,
  input  logic [WIDTH-1:0]         i_word,
  input  logic                     i_clear,
  output logic [LW-1:0]            o_lanes,
  output logic                     o_last,
  output logic [WIDTH*RATIO-1:0]   o_full_beat,
  output logic [WIDTH*RATIO-1:0]   o_partial_beat,
  output logic [RATIO-1:0]         o_partial_keep
);

  localparam logic [LW-1:0] LP_LAST = LW'(RATIO - 1);

  logic [LW-1:0]          r_lanes;
  logic [WIDTH*RATIO-1:0] r_acc;
  logic                   w_last;

  assign w_last = i_capture & (r_lanes == LP_LAST);

  // The accumulator is cleared whenever its contents leave, so lanes at or above
  // r_lanes are always zero and the top lane can simply be OR-ed in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lanes <= '0;
      r_acc   <= '0;
    end else if (w_last || i_clear) begin
      r_lanes <= '0;
      r_acc   <= '0;
    end else if (i_capture) begin
      r_acc[r_lanes*WIDTH +: WIDTH] <= i_word;
      r_lanes                       <= r_lanes + 1'b1;
    end
  end

  always_comb begin
    o_partial_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      o_partial_keep[i] = (LW'(i) < r_lanes);
    end
  end

  assign o_lanes        = r_lanes;
  assign o_last         = w_last;
  assign o_partial_beat = r_acc;
  assign o_full_beat    = r_acc | {i_word, {(WIDTH*(RATIO-1)){1'b0}}};

endmodule

// File: rtl/fifo_pop_packer.sv
// Read side of an SRL FIFO: pops WIDTH-bit words, packs RATIO of them into one
// beat on a valid/ready stream, and on flush emits any partial beat with a keep mask.
module fifo_pop_packer
  import fifo_pop_packer_pkg::*;
#(
  parameter int    WIDTH       = 8,
  parameter int    RATIO       = 4,
  parameter string FALLTHROUGH = "true"
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fifo_empty,
  output logic                   fifo_pop,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]       m_keep
);

  localparam int             LW          = lane_width(RATIO);
  localparam bit             LP_FT       = (FALLTHROUGH == "true");
  localparam logic [LW:0]    LP_RES_LAST = (LW+1)'(RATIO - 1);

  if (RATIO < 2) begin : g_ratio_check
    $error("fifo_pop_packer: RATIO must be at least 2");
  end

  state_e                 r_state;
  logic                   r_inflight;
  logic                   r_valid;
  logic [WIDTH*RATIO-1:0] r_data;
  logic [RATIO-1:0]       r_keep;

  logic [LW-1:0]          w_lanes;
  logic                   w_last;
  logic [WIDTH*RATIO-1:0] w_full_beat;
  logic [WIDTH*RATIO-1:0] w_partial_beat;
  logic [RATIO-1:0]       w_partial_keep;
  logic [LW:0]            w_reserved;
  logic                   w_room;
  logic                   w_pop;
  logic                   w_capture;
  logic                   w_emit_load;

  // The last free slot may only be reserved while the output register is empty,
  // so a completing beat never has to wait and no combinational m_ready path exists.
  assign w_reserved = {1'b0, w_lanes} + {{LW{1'b0}}, r_inflight};
  assign w_room     = (w_reserved < LP_RES_LAST) ||
                      ((w_reserved == LP_RES_LAST) && !r_valid);
  assign w_pop      = reset && (r_state == ST_RUN) && !fifo_empty && w_room;

  assign w_capture   = LP_FT ? w_pop : r_inflight;
  assign w_emit_load = (r_state == ST_EMIT) && !r_valid;

  fifo_pop_packer_lane_accumulator #(
    .WIDTH (WIDTH),
    .RATIO (RATIO),
    .LW    (LW)
  ) u_lane_accumulator (
    .clock          (clock),
    .reset          (reset),
    .i_capture      (w_capture),
    .i_word         (fifo_dout),
    .i_clear        (w_emit_load),
    .o_lanes        (w_lanes),
    .o_last         (w_last),
    .o_full_beat    (w_full_beat),
    .o_partial_beat (w_partial_beat),
    .o_partial_keep (w_partial_keep)
  );

  // Flush FSM and output register share one block so every output is registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_keep     <= '0;
    end else begin
      r_inflight <= LP_FT ? 1'b0 : w_pop;

      if (w_last) begin
        r_valid <= 1'b1;
        r_data  <= w_full_beat;
        r_keep  <= '1;
      end else if (w_emit_load) begin
        r_valid <= 1'b1;
        r_data  <= w_partial_beat;
        r_keep  <= w_partial_keep;
      end else if (r_valid && m_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_RUN: begin
          if (flush) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!r_inflight) r_state <= (w_lanes == '0) ? ST_RUN : ST_EMIT;
        end
        ST_EMIT: begin
          if (!r_valid) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign fifo_pop = w_pop;
  assign m_valid  = r_valid;
  assign m_data   = r_data;
  assign m_keep   = r_keep;

endmodule

// File: tb/tb_fifo_pop_packer.sv
// Runs a fall-through and a registered-output packer side by side against behavioural
// FIFOs; expected beats are packed from pushed words and compared on each handshake.
module tb_fifo_pop_packer;

  localparam int W = 8;
  localparam int R = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       fifoEmpty;
  logic [1:0]       fifoPop;
  logic [1:0]       flushReq;
  logic [1:0]       mValid;
  logic             mReady;
  logic [W-1:0]     fifoDout [2];
  logic [W*R-1:0]   mData [2];
  logic [R-1:0]     mKeep [2];

  fifo_pop_packer #(.WIDTH(W), .RATIO(R), .FALLTHROUGH("true")) dutTrue (
    .clock(clock), .reset(reset), .fifo_empty(fifoEmpty[0]), .fifo_pop(fifoPop[0]),
    .fifo_dout(fifoDout[0]), .flush(flushReq[0]), .m_valid(mValid[0]), .m_ready(mReady),
    .m_data(mData[0]), .m_keep(mKeep[0])
  );

  fifo_pop_packer #(.WIDTH(W), .RATIO(R), .FALLTHROUGH("false")) dutFalse (
    .clock(clock), .reset(reset), .fifo_empty(fifoEmpty[1]), .fifo_pop(fifoPop[1]),
    .fifo_dout(fifoDout[1]), .flush(flushReq[1]), .m_valid(mValid[1]), .m_ready(mReady),
    .m_data(mData[1]), .m_keep(mKeep[1])
  );

  logic [W-1:0]     fifoQ [2][$];
  logic [R+W*R-1:0] expQ [2][$];
  logic [W-1:0]     pending [$];
  int               checks = 0;
  int               failures = 0;
  int               popped [2];
  int               loaded [2];
  bit               heldPrev [2];
  logic [R+W*R-1:0] heldBeat [2];
  bit               armLane3 [2];
  bit               lastPop [2];

  function automatic logic [R+W*R-1:0] packPending();
    logic [W*R-1:0] d = '0;
    logic [R-1:0]   kp = '0;
    foreach (pending[i]) begin
      d[i*W +: W] = pending[i];
      kp[i] = 1'b1;
    end
    return {kp, d};
  endfunction

  task automatic refreshFifo();
    fifoEmpty[0] = (fifoQ[0].size() == 0);
    fifoDout[0]  = fifoEmpty[0] ? '0 : fifoQ[0][0];
    fifoEmpty[1] = (fifoQ[1].size() == 0);
  endtask

  task automatic pushWord(input logic [W-1:0] w);
    fifoQ[0].push_back(w);
    fifoQ[1].push_back(w);
    pending.push_back(w);
    if (pending.size() == R) begin
      expQ[0].push_back(packPending());
      expQ[1].push_back(packPending());
      pending.delete();
    end
    refreshFifo();
  endtask

  task automatic expectFlush();
    if (pending.size() > 0) begin
      expQ[0].push_back(packPending());
      expQ[1].push_back(packPending());
      pending.delete();
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < 2; k++) begin
      expQ[k].delete();
      popped[k]   = 0;
      loaded[k]   = 0;
      heldPrev[k] = 1'b0;
      armLane3[k] = 1'b0;
      lastPop[k]  = 1'b0;
    end
    pending.delete();
  endtask

  // One clock cycle: inspect outputs at the falling edge, then model the FIFOs after the rise.
  task automatic step();
    bit popNow [2];
    bit accept [2];
    bit wasValid [2];
    logic [R+W*R-1:0] exp;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      popNow[k]   = fifoPop[k];
      wasValid[k] = mValid[k];
      accept[k]   = mValid[k] && mReady;
      if (heldPrev[k] && mValid[k]) begin
        checks++;
        if ({mKeep[k], mData[k]} !== heldBeat[k]) begin
          failures++;
          $display("[TB] FAIL hold[%0d]: got %h expected %h", k, {mKeep[k], mData[k]}, heldBeat[k]);
        end
      end
      if (popNow[k] && mValid[k]) begin
        checks++;
        if (popped[k] - loaded[k] >= R - 1) begin
          failures++;
          $display("[TB] FAIL reserve[%0d]: got %0d reserved expected below %0d", k, popped[k] - loaded[k], R - 1);
        end
      end
      if (accept[k]) begin
        checks++;
        if (expQ[k].size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_beat[%0d]: got %h expected none", k, {mKeep[k], mData[k]});
        end else begin
          exp = expQ[k].pop_front();
          if ({mKeep[k], mData[k]} !== exp) begin
            failures++;
            $display("[TB] FAIL beat[%0d]: got %h expected %h", k, {mKeep[k], mData[k]}, exp);
          end
        end
      end
      heldPrev[k] = mValid[k] && !mReady;
      heldBeat[k] = {mKeep[k], mData[k]};
      if (armLane3[k] && popNow[k] && (popped[k] - loaded[k] == R - 1)) begin
        flushReq[k] = 1'b1;
        armLane3[k] = 1'b0;
      end
      if (popNow[k]) popped[k]++;
      lastPop[k] = popNow[k];
    end
    @(posedge clock);
    #1;
    flushReq = '0;
    if (popNow[0]) void'(fifoQ[0].pop_front());
    if (popNow[1]) fifoDout[1] = fifoQ[1].pop_front();
    refreshFifo();
    for (int k = 0; k < 2; k++) begin
      if (mValid[k] && (!wasValid[k] || accept[k])) loaded[k] += $countones(mKeep[k]);
    end
  endtask

  task automatic test_reset();
    mReady   = 1'b1;
    flushReq = '0;
    fifoDout[1] = '0;
    clearModel();
    refreshFifo();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mValid[k] !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid[%0d]: got %b expected 0", k, mValid[k]); end
      checks++;
      if (mData[k] !== '0) begin failures++; $display("[TB] FAIL reset_data[%0d]: got %h expected 0", k, mData[k]); end
      checks++;
      if (mKeep[k] !== '0) begin failures++; $display("[TB] FAIL reset_keep[%0d]: got %h expected 0", k, mKeep[k]); end
      checks++;
      if (fifoPop[k] !== 1'b0) begin failures++; $display("[TB] FAIL reset_pop[%0d]: got %b expected 0", k, fifoPop[k]); end
    end
    repeat (2) step();
  endtask

  task automatic test_full_rate();
    int first = -1;
    int last = -1;
    int pops = 0;
    mReady = 1'b1;
    for (int i = 1; i <= 8; i++) pushWord(W'(i));
    for (int c = 0; c < 60 && (expQ[0].size() + expQ[1].size() > 0); c++) begin
      step();
      if (lastPop[0]) begin
        if (first < 0) first = c;
        last = c;
        pops++;
      end
    end
    repeat (4) step();
    checks++;
    if (pops != 8) begin failures++; $display("[TB] FAIL full_rate_pops: got %0d expected 8", pops); end
    checks++;
    if (last - first != 7) begin failures++; $display("[TB] FAIL full_rate_span: got %0d expected 7", last - first); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (expQ[k].size() != 0) begin failures++; $display("[TB] FAIL full_rate_missing[%0d]: got %0d left expected 0", k, expQ[k].size()); end
    end
  endtask

  task automatic test_backpressure();
    mReady = 1'b0;
    for (int i = 0; i < 12; i++) pushWord(W'(8'h20 + i));
    repeat (10) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (fifoPop[k] !== 1'b0) begin failures++; $display("[TB] FAIL bp_pop[%0d]: got %b expected 0", k, fifoPop[k]); end
      checks++;
      if (fifoQ[k].size() != 5) begin failures++; $display("[TB] FAIL bp_left[%0d]: got %0d expected 5", k, fifoQ[k].size()); end
      checks++;
      if (mValid[k] !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", k, mValid[k]); end
    end
    mReady = 1'b1;
    for (int c = 0; c < 60 && (expQ[0].size() + expQ[1].size() > 0); c++) step();
    repeat (4) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (expQ[k].size() != 0) begin failures++; $display("[TB] FAIL bp_missing[%0d]: got %0d left expected 0", k, expQ[k].size()); end
    end
  endtask

  task automatic test_flush_partial();
    mReady = 1'b1;
    pushWord(8'h0A);
    pushWord(8'h0B);
    repeat (4) step();
    flushReq = '1;
    expectFlush();
    for (int c = 0; c < 30 && (expQ[0].size() + expQ[1].size() > 0); c++) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (expQ[k].size() != 0) begin failures++; $display("[TB] FAIL flush_missing[%0d]: got %0d left expected 0", k, expQ[k].size()); end
    end
    repeat (2) step();
    flushReq = '1;
    expectFlush();
    repeat (8) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mValid[k] !== 1'b0) begin failures++; $display("[TB] FAIL empty_flush_valid[%0d]: got %b expected 0", k, mValid[k]); end
    end
  endtask

  task automatic test_flush_lane3();
    mReady = 1'b1;
    armLane3[0] = 1'b1;
    armLane3[1] = 1'b1;
    for (int i = 0; i < 4; i++) pushWord(W'(8'h40 + i));
    for (int c = 0; c < 30 && (expQ[0].size() + expQ[1].size() > 0); c++) step();
    repeat (6) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (armLane3[k] !== 1'b0) begin failures++; $display("[TB] FAIL lane3_flush_sent[%0d]: got armed expected sent", k); end
      checks++;
      if (expQ[k].size() != 0) begin failures++; $display("[TB] FAIL lane3_missing[%0d]: got %0d left expected 0", k, expQ[k].size()); end
    end
    for (int i = 0; i < 4; i++) pushWord(W'(8'h50 + i));
    for (int c = 0; c < 30 && (expQ[0].size() + expQ[1].size() > 0); c++) step();
    repeat (4) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (expQ[k].size() != 0) begin failures++; $display("[TB] FAIL lane3_resume[%0d]: got %0d left expected 0", k, expQ[k].size()); end
    end
  endtask

  task automatic test_reset_midbeat();
    mReady = 1'b0;
    for (int i = 0; i < 6; i++) pushWord(W'(8'h60 + i));
    repeat (10) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mValid[k] !== 1'b1) begin failures++; $display("[TB] FAIL midbeat_valid[%0d]: got %b expected 1", k, mValid[k]); end
    end
    #2;
    reset = 1'b0;
    clearModel();
    for (int i = 0; i < 4; i++) pushWord(W'(8'h70 + i));
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mValid[k] !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid[%0d]: got %b expected 0", k, mValid[k]); end
      checks++;
      if (fifoPop[k] !== 1'b0) begin failures++; $display("[TB] FAIL midreset_pop[%0d]: got %b expected 0", k, fifoPop[k]); end
    end
    repeat (2) step();
    reset  = 1'b1;
    mReady = 1'b1;
    for (int c = 0; c < 30 && (expQ[0].size() + expQ[1].size() > 0); c++) step();
    repeat (4) step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (expQ[k].size() != 0) begin failures++; $display("[TB] FAIL postreset_missing[%0d]: got %0d left expected 0", k, expQ[k].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_flush_partial();
    test_flush_lane3();
    test_reset_midbeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
